// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial add scheduler.
// Holds the FSM encoding and the round-robin pick function.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;
    localparam int MAX_REQ   = 8;

    // First valid index at or after ptr, wrapping modulo n.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && valid[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial full adder with a carry flop.
// Carry clears after the last bit so each operation starts clean.
module serial_add_core (
    input  logic clk,
    input  logic rst,
    input  logic vld,
    input  logic a,
    input  logic b,
    input  logic last,
    output logic s,
    output logic cout
);

    logic c;

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));

    always_ff @(posedge clk) begin
        if (rst) begin
            c <= 1'b0;
        end else if (vld) begin
            c <= last ? 1'b0 : cout;
        end
    end

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler feeding one bit-serial adder core.
// Serializes granted operand pairs LSB-first and returns tagged sums.
module serial_add_scheduler
    import serial_add_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*W-1:0]        req_a,
    input  logic [N_REQ*W-1:0]        req_b,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [W:0]                resp_sum,
    output logic [$clog2(N_REQ)-1:0]  resp_id,
    output logic                      busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(W);

    sched_state_t   state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] id;
    logic [2:0]     pick;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   op_a, op_b;
    logic [W-1:0]   res;
    logic           msb;
    logic           accept;
    logic           vld, last, s, cout;

    assign pick   = rr_pick(MAX_REQ'(req_valid), 3'(rr_ptr), N_REQ);
    assign win    = pick[IDW-1:0];
    assign accept = (state == IDLE) && !rst && (|req_valid);

    assign req_ready  = accept ? (N_REQ'(1) << win) : '0;
    assign last       = (cnt == CW'(W - 1));
    assign resp_valid = (state == DONE);
    assign resp_sum   = {msb, res};
    assign resp_id    = id;
    assign busy       = (state != IDLE);

    serial_add_core u_core (
        .clk  (clk),
        .rst  (rst),
        .vld  (vld),
        .a    (op_a[cnt]),
        .b    (op_b[cnt]),
        .last (last),
        .s    (s),
        .cout (cout)
    );

    always_comb begin
        state_nxt = state;
        vld       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = SHIFT;
            end
            SHIFT: begin
                vld = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            id     <= '0;
            res    <= '0;
            msb    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a   <= req_a[int'(win)*W +: W];
                op_b   <= req_b[int'(win)*W +: W];
                id     <= win;
                rr_ptr <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
                cnt    <= '0;
            end
            // Sum bits enter at the top and walk down to bit 0.
            if (vld) begin
                res <= {s, res[W-1:1]};
                cnt <= cnt + 1'b1;
                if (last) msb <= cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Scoreboard bench for serial_add_scheduler.
// Accepts push expected sums; responses pop and compare.
module tb_serial_add_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct {
        int         id;
        logic [W:0] sum;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           resp_valid;
    logic           resp_ready;
    logic [W:0]     resp_sum;
    logic [1:0]     resp_id;
    logic           busy;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_resp = 0;
    int acc_cyc = 0;
    int rr_cnt = 0;
    bit rr_phase = 1'b0;
    logic prev_rv = 1'b0;

    logic [W-1:0] ta [N];
    logic [W-1:0] tb_ [N];
    exp_t sb [$];
    int   gq [$];
    exp_t e;

    serial_add_scheduler #(.N_REQ(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id  = i;
                    e.sum = {1'b0, ta[i]} + {1'b0, tb_[i]};
                    sb.push_back(e);
                    gq.push_back(i);
                    if (rr_phase && rr_cnt > 0)
                        check("issue_interval", cyc - acc_cyc, W + 2);
                    if (rr_phase) rr_cnt++;
                    acc_cyc = cyc;
                    n_acc++;
                end
            end
            if (resp_valid && !prev_rv)
                check("resp_latency", cyc - acc_cyc, W + 1);
            if (resp_valid && resp_ready) begin
                check("resp_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("resp_sum", resp_sum, e.sum);
                    check("resp_id", resp_id, e.id);
                end
                n_resp++;
            end
        end
        prev_rv = resp_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b);
        ta[i]  = a;
        tb_[i] = b;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic wait_acc(input int target, input string tag);
        int k = 0;
        while (n_acc < target && k < 200) begin
            tick();
            k++;
        end
        check(tag, n_acc >= target, 1);
    endtask

    task automatic wait_resp(input int target, input string tag);
        int k = 0;
        while (n_resp < target && k < 200) begin
            tick();
            k++;
        end
        check(tag, n_resp >= target, 1);
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        check({tag, "_n"}, gq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            check(tag, (i < gq.size()) ? gq[i] : -1, exp[i]);
    endtask

    initial begin
        int k;
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, '0, '0);
        tick();
        req_valid = '1;
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", resp_sum, 0);
        check("rst_id", resp_id, 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // single add
        set_op(0, 8'd200, 8'd100);
        req_valid = 4'b0001;
        wait_acc(1, "single_acc");
        req_valid = '0;
        wait_resp(1, "single_resp");

        // carry-out then zero back-to-back
        set_op(0, 8'hFF, 8'h01);
        req_valid = 4'b0001;
        wait_acc(2, "carry_acc");
        set_op(0, 8'h00, 8'h00);
        wait_acc(3, "zero_acc");
        req_valid = '0;
        wait_resp(3, "carry_resp");

        // pointer wrap
        gq.delete();
        set_op(3, 8'h3C, 8'h11);
        req_valid = 4'b1000;
        wait_acc(4, "wrap_acc3");
        set_op(0, 8'h81, 8'h90);
        set_op(3, 8'h42, 8'h24);
        req_valid = 4'b1001;
        wait_acc(5, "wrap_acc0");
        req_valid = 4'b1000;
        wait_acc(6, "wrap_acc3b");
        req_valid = '0;
        wait_resp(6, "wrap_resp");
        check_order("wrap_order", '{3, 0, 3});

        // round-robin with all requesters pending
        gq.delete();
        set_op(0, 8'd17, 8'd250);
        set_op(1, 8'd99, 8'd3);
        set_op(2, 8'd128, 8'd128);
        set_op(3, 8'd1, 8'd64);
        rr_phase = 1'b1;
        rr_cnt = 0;
        req_valid = '1;
        wait_acc(11, "rr_acc");
        req_valid = '0;
        rr_phase = 1'b0;
        wait_resp(11, "rr_resp");
        check_order("rr_order", '{0, 1, 2, 3, 0});

        // backpressure in DONE
        resp_ready = 1'b0;
        set_op(1, 8'hAB, 8'hCD);
        req_valid = 4'b0010;
        wait_acc(12, "bp_acc");
        set_op(2, 8'h55, 8'h66);
        req_valid = 4'b0100;
        k = 0;
        while (!resp_valid && k < 50) begin
            tick();
            k++;
        end
        check("bp_valid", resp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_sum", resp_sum,
                  (sb.size() > 0) ? sb[0].sum : 'x);
            check("bp_id", resp_id,
                  (sb.size() > 0) ? sb[0].id : -1);
            check("bp_ready", req_ready, 0);
            check("bp_no_accept", n_acc, 12);
            tick();
        end
        resp_ready = 1'b1;
        wait_acc(13, "bp_acc2");
        req_valid = '0;
        wait_resp(13, "bp_resp");

        // reset in the middle of SHIFT
        set_op(3, 8'h0F, 8'h0F);
        req_valid = 4'b1000;
        wait_acc(14, "rs_acc");
        req_valid = '0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        set_op(0, 8'h7E, 8'h99);
        set_op(1, 8'h01, 8'h02);
        set_op(2, 8'h03, 8'h04);
        set_op(3, 8'h05, 8'h06);
        req_valid = '1;
        tick();
        check("rs_busy", busy, 0);
        check("rs_valid", resp_valid, 0);
        check("rs_ready", req_ready, 0);
        check("rs_noresp", n_resp, 13);
        sb.delete();
        gq.delete();
        rst = 1'b0;
        wait_acc(15, "rs_acc2");
        req_valid = '0;
        wait_resp(14, "rs_resp");
        check_order("rs_order", '{0});
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
